// File: rtl/regfile_mmio_if.sv
// Register-file bus: write port, two read ports, switch input and display output.
interface regfile_mmio_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned USER_WIDTH = 6
);
    logic                  RegWrite;
    logic [ADDR_WIDTH-1:0] writeRegister;
    logic [DATA_WIDTH-1:0] writeData;
    logic [ADDR_WIDTH-1:0] readRegister1;
    logic [ADDR_WIDTH-1:0] readRegister2;
    logic [USER_WIDTH-1:0] user_number;
    logic [DATA_WIDTH-1:0] readData1;
    logic [DATA_WIDTH-1:0] readData2;
    logic [DATA_WIDTH-1:0] toDisplay;
    logic                  display_strobe;

    // Datapath side: drives indices and data, consumes read results.
    modport master (
        output RegWrite, writeRegister, writeData, readRegister1, readRegister2, user_number,
        input  readData1, readData2, toDisplay, display_strobe
    );

    // Register file side.
    modport slave (
        input  RegWrite, writeRegister, writeData, readRegister1, readRegister2, user_number,
        output readData1, readData2, toDisplay, display_strobe
    );
endinterface

// File: rtl/regfile_mmio.sv
// Register file with registered reads, hardwired r0, a switch-input register
// loaded every cycle and a display-output register mirrored with a change strobe.
module regfile_mmio #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 5,
    parameter int unsigned USER_WIDTH  = 6,
    parameter int unsigned IO_IN_REG   = 30,
    parameter int unsigned IO_OUT_REG  = 31,
    parameter bit          WRITE_FIRST = 1'b1
) (
    input logic           clock,
    input logic           reset,
    regfile_mmio_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] IN_IDX  = ADDR_WIDTH'(IO_IN_REG);
    localparam logic [ADDR_WIDTH-1:0] OUT_IDX = ADDR_WIDTH'(IO_OUT_REG);

    // Reject parameter sets that would alias the I/O registers or truncate the switches.
    if (IO_IN_REG == 0 || IO_IN_REG >= DEPTH) begin : g_bad_in_reg
        $error("regfile_mmio: IO_IN_REG must be nonzero and below the depth");
    end
    if (IO_OUT_REG == 0 || IO_OUT_REG >= DEPTH) begin : g_bad_out_reg
        $error("regfile_mmio: IO_OUT_REG must be nonzero and below the depth");
    end
    if (IO_IN_REG == IO_OUT_REG) begin : g_bad_io_alias
        $error("regfile_mmio: IO_IN_REG and IO_OUT_REG must differ");
    end
    if (USER_WIDTH > DATA_WIDTH) begin : g_bad_user_width
        $error("regfile_mmio: USER_WIDTH must not exceed DATA_WIDTH");
    end

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic [DATA_WIDTH-1:0] read_data1, read_data2, to_display;
    logic                  strobe;

    logic                  write_ok;
    logic [DATA_WIDTH-1:0] switch_value;
    logic [DATA_WIDTH-1:0] rd1_next, rd2_next, display_next;
    logic                  strobe_next;

    // Value a read port captures: post-edge contents when write-first, stored contents otherwise.
    function automatic logic [DATA_WIDTH-1:0] read_pick(
        input logic [ADDR_WIDTH-1:0] idx,
        input logic [DATA_WIDTH-1:0] stored,
        input logic                  wok,
        input logic [ADDR_WIDTH-1:0] widx,
        input logic [DATA_WIDTH-1:0] wdata,
        input logic [DATA_WIDTH-1:0] sw
    );
        if (idx == '0) return '0;
        if (!WRITE_FIRST) return stored;
        if (idx == IN_IDX) return sw;
        if (wok && idx == widx) return wdata;
        return stored;
    endfunction

    // Next-state decode for reads, display mirror and change strobe.
    always_comb begin
        write_ok     = bus.RegWrite && (bus.writeRegister != '0) && (bus.writeRegister != IN_IDX);
        switch_value = DATA_WIDTH'(bus.user_number);
        rd1_next     = read_pick(bus.readRegister1, regs[bus.readRegister1], write_ok,
                                 bus.writeRegister, bus.writeData, switch_value);
        rd2_next     = read_pick(bus.readRegister2, regs[bus.readRegister2], write_ok,
                                 bus.writeRegister, bus.writeData, switch_value);
        display_next = (write_ok && bus.writeRegister == OUT_IDX) ? bus.writeData : regs[OUT_IDX];
        strobe_next  = (display_next != to_display);
    end

    // Storage: write port plus the unconditional switch load; r0 is never written.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else begin
            if (write_ok) regs[bus.writeRegister] <= bus.writeData;
            regs[IN_IDX] <= switch_value;
        end
    end

    // Registered read ports, display copy and strobe.
    always_ff @(posedge clock) begin
        if (reset) begin
            read_data1 <= '0;
            read_data2 <= '0;
            to_display <= '0;
            strobe     <= 1'b0;
        end else begin
            read_data1 <= rd1_next;
            read_data2 <= rd2_next;
            to_display <= display_next;
            strobe     <= strobe_next;
        end
    end

    assign bus.readData1      = read_data1;
    assign bus.readData2      = read_data2;
    assign bus.toDisplay      = to_display;
    assign bus.display_strobe = strobe;
endmodule

// File: tb/tb_regfile_mmio.sv
// Scoreboard bench: a write-first and a read-first instance share one stimulus stream;
// a behavioural model queues the expected outputs of each edge, compared after the edge.
module tb_regfile_mmio;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int UW = 6;

    typedef struct {
        logic [DW-1:0] rd1_wf, rd2_wf, rd1_rf, rd2_rf, disp;
        logic          strobe;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    logic          reg_write;
    logic [AW-1:0] wr_addr, ra1, ra2;
    logic [DW-1:0] wr_data;
    logic [UW-1:0] user;

    int n_checks = 0;
    int n_errors = 0;

    exp_t          sb[$];
    logic [DW-1:0] model [32];
    logic [DW-1:0] model_disp;

    always #5 clock = ~clock;

    regfile_mmio_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .USER_WIDTH(UW)) bus_wf ();
    regfile_mmio_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .USER_WIDTH(UW)) bus_rf ();

    assign bus_wf.RegWrite      = reg_write;
    assign bus_wf.writeRegister = wr_addr;
    assign bus_wf.writeData     = wr_data;
    assign bus_wf.readRegister1 = ra1;
    assign bus_wf.readRegister2 = ra2;
    assign bus_wf.user_number   = user;
    assign bus_rf.RegWrite      = reg_write;
    assign bus_rf.writeRegister = wr_addr;
    assign bus_rf.writeData     = wr_data;
    assign bus_rf.readRegister1 = ra1;
    assign bus_rf.readRegister2 = ra2;
    assign bus_rf.user_number   = user;

    regfile_mmio #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .USER_WIDTH(UW),
        .IO_IN_REG(30), .IO_OUT_REG(31), .WRITE_FIRST(1'b1)
    ) dut_wf (
        .clock(clock),
        .reset(reset),
        .bus  (bus_wf)
    );

    regfile_mmio #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .USER_WIDTH(UW),
        .IO_IN_REG(30), .IO_OUT_REG(31), .WRITE_FIRST(1'b0)
    ) dut_rf (
        .clock(clock),
        .reset(reset),
        .bus  (bus_rf)
    );

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Predict this edge from the current inputs, queue it, advance the model.
    task automatic predict();
        exp_t          e;
        logic [DW-1:0] nxt [32];
        if (reset) begin
            e = '{rd1_wf: '0, rd2_wf: '0, rd1_rf: '0, rd2_rf: '0, disp: '0, strobe: 1'b0};
            for (int i = 0; i < 32; i++) model[i] = '0;
            model_disp = '0;
        end else begin
            for (int i = 0; i < 32; i++) nxt[i] = model[i];
            if (reg_write && wr_addr != 0 && wr_addr != 30) nxt[wr_addr] = wr_data;
            nxt[30] = {26'd0, user};
            e.rd1_wf = nxt[ra1];
            e.rd2_wf = nxt[ra2];
            e.rd1_rf = (ra1 == 0) ? '0 : model[ra1];
            e.rd2_rf = (ra2 == 0) ? '0 : model[ra2];
            e.disp   = nxt[31];
            e.strobe = (nxt[31] != model_disp);
            for (int i = 0; i < 32; i++) model[i] = nxt[i];
            model_disp = nxt[31];
        end
        sb.push_back(e);
    endtask

    // One clock: queue expectation, take the edge, compare both instances #1 later.
    task automatic step();
        exp_t e;
        predict();
        @(posedge clock);
        #1;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("wf_rd1", bus_wf.readData1, e.rd1_wf);
            check("wf_rd2", bus_wf.readData2, e.rd2_wf);
            check("rf_rd1", bus_rf.readData1, e.rd1_rf);
            check("rf_rd2", bus_rf.readData2, e.rd2_rf);
            check("wf_disp", bus_wf.toDisplay, e.disp);
            check("rf_disp", bus_rf.toDisplay, e.disp);
            check("wf_strobe", DW'(bus_wf.display_strobe), DW'(e.strobe));
            check("rf_strobe", DW'(bus_rf.display_strobe), DW'(e.strobe));
        end
    endtask

    task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        reg_write = we;
        wr_addr   = wa;
        wr_data   = wd;
        ra1       = r1;
        ra2       = r2;
    endtask

    initial begin
        reset = 1'b1;
        user  = '0;
        drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0);
        for (int i = 0; i < 32; i++) model[i] = '0;
        model_disp = '0;

        // Reset held two cycles while a write is presented.
        step();
        step();
        reset = 1'b0;
        drive(1'b0, 5'd0, '0, 5'd5, 5'd5);
        step();
        check("rst_r5_read", bus_wf.readData1, 32'd0);
        check("rst_disp", bus_wf.toDisplay, 32'd0);
        check("rst_strobe", DW'(bus_wf.display_strobe), 32'd0);

        // Writes to r0 and the switch register are dropped.
        user = 6'h2A;
        drive(1'b1, 5'd0, 32'h1234, 5'd0, 5'd0);
        step();
        drive(1'b1, 5'd30, 32'h1234, 5'd0, 5'd30);
        step();
        drive(1'b0, 5'd0, '0, 5'd0, 5'd30);
        step();
        check("r0_zero", bus_wf.readData1, 32'd0);
        check("r30_switch", bus_wf.readData2, 32'h2A);

        // Write-through versus read-first on r7.
        drive(1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd7);
        step();
        check("wf_through", bus_wf.readData1, 32'hA5A5A5A5);
        check("rf_old", bus_rf.readData1, 32'd0);
        drive(1'b0, 5'd0, '0, 5'd7, 5'd7);
        step();
        check("rf_new", bus_rf.readData1, 32'hA5A5A5A5);

        // Display path and strobe.
        drive(1'b1, 5'd31, 32'h9, 5'd31, 5'd31);
        step();
        check("disp_9", bus_wf.toDisplay, 32'h9);
        check("strobe_9", DW'(bus_wf.display_strobe), 32'd1);
        drive(1'b0, 5'd0, '0, 5'd31, 5'd31);
        step();
        check("strobe_one_cycle", DW'(bus_wf.display_strobe), 32'd0);
        drive(1'b1, 5'd31, 32'h9, 5'd31, 5'd0);
        step();
        check("strobe_same", DW'(bus_wf.display_strobe), 32'd0);
        drive(1'b1, 5'd31, 32'h10, 5'd31, 5'd0);
        step();
        check("strobe_10", DW'(bus_wf.display_strobe), 32'd1);

        // Switch tracking on port 2.
        drive(1'b0, 5'd0, '0, 5'd0, 5'd30);
        user = 6'h01;
        step();
        check("sw_01", bus_wf.readData2, 32'h1);
        user = 6'h3F;
        step();
        check("sw_3f", bus_wf.readData2, 32'h3F);

        // Reset overriding a display write.
        reset = 1'b1;
        drive(1'b1, 5'd31, 32'hFF, 5'd31, 5'd31);
        step();
        check("rst_mid_disp", bus_wf.toDisplay, 32'd0);
        check("rst_mid_strobe", DW'(bus_wf.display_strobe), 32'd0);
        reset = 1'b0;
        drive(1'b0, 5'd0, '0, 5'd31, 5'd31);
        step();
        check("rst_mid_r31", bus_wf.readData1, 32'd0);

        // Random traffic, biased towards the I/O registers and shared read indices.
        for (int n = 0; n < 60; n++) begin
            logic [AW-1:0] a1;
            a1 = AW'($urandom_range(0, 31));
            drive(1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0) ? 5'd31 : AW'($urandom_range(0, 31)),
                  ($urandom_range(0, 2) == 0) ? 32'h9 : $urandom,
                  a1,
                  ($urandom_range(0, 2) == 0) ? a1 : AW'($urandom_range(0, 31)));
            user = UW'($urandom);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end
endmodule
